// File: rtl/rpu_pkg.sv
// Shared defaults for the check-node min-finder blocks: widths, degree and
// offset, plus the index-width helper used to size position counters.
package rpu_pkg;

    localparam int RPU_W      = 6;
    localparam int RPU_DEG    = 8;
    localparam int RPU_OFFSET = 1;

    function automatic int idx_width(input int deg);
        if (deg > 1) begin
            return $clog2(deg);
        end else begin
            return 1;
        end
    endfunction

    localparam int RPU_IDXW    = idx_width(RPU_DEG);
    localparam int RPU_MAG_MAX = (2 ** (RPU_W - 1)) - 1;

endpackage

// File: rtl/rpu_min_cmp_update.sv
// Combinational two-minimum tracker step: folds one magnitude into the
// running (min1, min2, idx) triple using strict comparisons.
module rpu_min_cmp_update #(
    parameter int MW   = 5,
    parameter int IDXW = 3
) (
    input  logic [MW-1:0]   min1_i,
    input  logic [MW-1:0]   min2_i,
    input  logic [IDXW-1:0] idx_i,
    input  logic [IDXW-1:0] cnt_i,
    input  logic [MW-1:0]   mag_i,
    output logic [MW-1:0]   min1_o,
    output logic [MW-1:0]   min2_o,
    output logic [IDXW-1:0] idx_o
);

    // Ties with min1 fall through to min2 so idx keeps the earliest position.
    always_comb begin
        min1_o = min1_i;
        min2_o = min2_i;
        idx_o  = idx_i;
        if (mag_i < min1_i) begin
            min2_o = min1_i;
            min1_o = mag_i;
            idx_o  = cnt_i;
        end else if (mag_i < min2_i) begin
            min2_o = mag_i;
        end else begin
            min2_o = min2_i;
        end
    end

endmodule

// File: rtl/rpu_min_finder.sv
// Row-serial min-sum check-node front end: finds min1/min2/idx and sign data
// over DEG messages. Define RPU_MINF_OFFSET_EN for offset min-sum outputs.
module rpu_min_finder
    import rpu_pkg::*;
#(
    parameter int W      = RPU_W,
    parameter int DEG    = RPU_DEG,
    parameter int OFFSET = RPU_OFFSET,
    parameter int IDXW   = idx_width(DEG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sign,
    input  logic [W-2:0]    in_mag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-2:0]    out_min1,
    output logic [W-2:0]    out_min2,
    output logic [IDXW-1:0] out_idx,
    output logic            out_sign_prod,
    output logic [DEG-1:0]  out_signs
);

    localparam logic [W-2:0]    MAG_MAX = {(W-1){1'b1}};
    localparam logic [W-2:0]    OFF_V   = (W-1)'(OFFSET);
    localparam logic [IDXW-1:0] CNT_LAST = IDXW'(DEG - 1);
`ifdef RPU_MINF_OFFSET_EN
    localparam logic OFF_EN = 1'b1;
`else
    localparam logic OFF_EN = 1'b0;
`endif

    function automatic logic [W-2:0] apply_offset(input logic [W-2:0] m);
        if (!OFF_EN) begin
            return m;
        end else if (m > OFF_V) begin
            return m - OFF_V;
        end else begin
            return {(W-1){1'b0}};
        end
    endfunction

    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [W-2:0]    min1_q, min1_d, min2_q, min2_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            sign_prod_q, sign_prod_d;
    logic [DEG-1:0]  signs_q, signs_d;

    logic            out_valid_q, out_valid_d;
    logic [W-2:0]    out_min1_q, out_min1_d, out_min2_q, out_min2_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic            out_sign_prod_q, out_sign_prod_d;
    logic [DEG-1:0]  out_signs_q, out_signs_d;

    logic [W-2:0]    upd_min1_s, upd_min2_s;
    logic [IDXW-1:0] upd_idx_s;
    logic [DEG-1:0]  upd_signs_s;
    logic            upd_sign_prod_s;
    logic            last_s, accept_s, load_s;

    rpu_min_cmp_update #(
        .MW   (W - 1),
        .IDXW (IDXW)
    ) u_cmp (
        .min1_i (min1_q),
        .min2_i (min2_q),
        .idx_i  (idx_q),
        .cnt_i  (cnt_q),
        .mag_i  (in_mag),
        .min1_o (upd_min1_s),
        .min2_o (upd_min2_s),
        .idx_o  (upd_idx_s)
    );

    assign last_s   = (cnt_q == CNT_LAST);
    // Only the last message of a row must wait for a held result to drain.
    assign in_ready = !(last_s && out_valid_q && !out_ready);
    assign accept_s = in_valid && in_ready;
    assign load_s   = accept_s && last_s;

    // Row values including the message presented this cycle.
    always_comb begin
        upd_signs_s         = signs_q;
        upd_signs_s[cnt_q]  = in_sign;
        upd_sign_prod_s     = sign_prod_q ^ in_sign;
    end

    // Accumulator and position counter next state.
    always_comb begin
        cnt_d       = cnt_q;
        min1_d      = min1_q;
        min2_d      = min2_q;
        idx_d       = idx_q;
        sign_prod_d = sign_prod_q;
        signs_d     = signs_q;
        if (load_s) begin
            cnt_d       = {IDXW{1'b0}};
            min1_d      = MAG_MAX;
            min2_d      = MAG_MAX;
            idx_d       = {IDXW{1'b0}};
            sign_prod_d = 1'b0;
            signs_d     = {DEG{1'b0}};
        end else if (accept_s) begin
            cnt_d       = cnt_q + IDXW'(1);
            min1_d      = upd_min1_s;
            min2_d      = upd_min2_s;
            idx_d       = upd_idx_s;
            sign_prod_d = upd_sign_prod_s;
            signs_d     = upd_signs_s;
        end else begin
            cnt_d       = cnt_q;
        end
    end

    // Result registers: a new row overrides a same-cycle consume.
    always_comb begin
        out_valid_d     = out_valid_q;
        out_min1_d      = out_min1_q;
        out_min2_d      = out_min2_q;
        out_idx_d       = out_idx_q;
        out_sign_prod_d = out_sign_prod_q;
        out_signs_d     = out_signs_q;
        if (load_s) begin
            out_valid_d     = 1'b1;
            out_min1_d      = apply_offset(upd_min1_s);
            out_min2_d      = apply_offset(upd_min2_s);
            out_idx_d       = upd_idx_s;
            out_sign_prod_d = upd_sign_prod_s;
            out_signs_d     = upd_signs_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d     = 1'b0;
        end else begin
            out_valid_d     = out_valid_q;
        end
    end

    // State registers; reset discards any partial row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= {IDXW{1'b0}};
            min1_q          <= MAG_MAX;
            min2_q          <= MAG_MAX;
            idx_q           <= {IDXW{1'b0}};
            sign_prod_q     <= 1'b0;
            signs_q         <= {DEG{1'b0}};
            out_valid_q     <= 1'b0;
            out_min1_q      <= MAG_MAX;
            out_min2_q      <= MAG_MAX;
            out_idx_q       <= {IDXW{1'b0}};
            out_sign_prod_q <= 1'b0;
            out_signs_q     <= {DEG{1'b0}};
        end else begin
            cnt_q           <= cnt_d;
            min1_q          <= min1_d;
            min2_q          <= min2_d;
            idx_q           <= idx_d;
            sign_prod_q     <= sign_prod_d;
            signs_q         <= signs_d;
            out_valid_q     <= out_valid_d;
            out_min1_q      <= out_min1_d;
            out_min2_q      <= out_min2_d;
            out_idx_q       <= out_idx_d;
            out_sign_prod_q <= out_sign_prod_d;
            out_signs_q     <= out_signs_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_min1      = out_min1_q;
    assign out_min2      = out_min2_q;
    assign out_idx       = out_idx_q;
    assign out_sign_prod = out_sign_prod_q;
    assign out_signs     = out_signs_q;

endmodule

// File: doc/rpu_min_finder.md
RPU_MIN_FINDER -- requirements
Module: rpu_min_finder

Interface
REQ-001 SHALL have parameter W, default 6: message width in bits including the sign; magnitude width is W-1.
REQ-002 SHALL have parameter DEG, default 8: number of messages per row (check-node degree), DEG >= 2.
REQ-003 SHALL have parameter OFFSET, default 1: magnitude offset, used only under RPU_MINF_OFFSET_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream sign/magnitude message present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the message this cycle.
REQ-008 SHALL have port in_sign, input, 1 bit: message sign (1 = negative).
REQ-009 SHALL have port in_mag, input, W-1 bits: message magnitude, unsigned, at most 2^(W-1)-1.
REQ-010 SHALL have port out_valid, output, 1 bit: row result held.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-012 SHALL have port out_min1, output, W-1 bits: smallest magnitude in the row.
REQ-013 SHALL have port out_min2, output, W-1 bits: second-smallest magnitude in the row.
REQ-014 SHALL have port out_idx, output, IDXW = clog2(DEG) bits: position of min1 in the row.
REQ-015 SHALL have port out_sign_prod, output, 1 bit: XOR of all signs in the row.
REQ-016 SHALL have port out_signs, output, DEG bits: bit k is the sign of the k-th message.

Function
REQ-017 SHALL accept a message on any cycle with in_valid && in_ready; a position counter cnt (0..DEG-1) SHALL increment per accept and wrap to 0 after DEG-1.
REQ-018 SHALL hold accumulators min1, min2 (init MAG_MAX = 2^(W-1)-1), idx (init 0), sign_prod (init 0) and signs (init 0).
REQ-019 SHALL update per accept: if in_mag < min1 then min2 <= min1, min1 <= in_mag, idx <= cnt; else if in_mag < min2 then min2 <= in_mag; comparisons are strict, so a tie with min1 goes to min2 and idx keeps the earlier position.
REQ-020 SHALL update per accept: sign_prod ^= in_sign and signs[cnt] <= in_sign.
REQ-021 SHALL, on accepting the message at cnt == DEG-1, load the output registers with the final values including that message, set out_valid = 1 the next cycle (latency 1 cycle from the last accept), and re-initialise the accumulators in the same edge.
REQ-022 SHALL drive in_ready = !(cnt == DEG-1 && out_valid && !out_ready); the next row accumulates while a result is held, and only the row's last message stalls.
REQ-023 SHALL clear out_valid on out_ready && out_valid unless a new result loads in the same cycle, in which case out_valid SHALL stay 1 and the outputs SHALL take the new row.
REQ-024 SHALL keep the output registers stable while out_valid && !out_ready.
REQ-025 SHALL give out_min1 = out_min2 = MAG_MAX and out_idx = 0 when all magnitudes of a row equal MAG_MAX.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-row, asynchronously clear cnt, out_valid, out_idx, out_sign_prod and out_signs, set out_min1 = out_min2 = MAG_MAX, and re-initialise the accumulators; partial row data SHALL be discarded.
REQ-027 SHALL drive in_ready = 1 in the first cycle after reset release.

Configuration
REQ-028 SHALL, with RPU_MINF_OFFSET_EN defined, load out_min1 = max(min1-OFFSET, 0) and out_min2 = max(min2-OFFSET, 0) (offset min-sum); without the macro it SHALL load raw min1 and min2. No other behaviour changes.

Structure
REQ-029 SHALL take W, DEG, IDXW, MAG_MAX and OFFSET defaults from shared package rpu_pkg.
REQ-030 SHALL implement the compare-and-update of REQ-019 in combinational sub-module rpu_min_cmp_update.

Verification (W=6, DEG=4, no macro unless stated)
REQ-031 SHALL cover: mags 5,3,7,3 with signs 0,1,1,0 -> out_min1=3, out_min2=3, out_idx=1, out_sign_prod=0, out_signs=4'b0110.
REQ-032 SHALL cover: four mags of 31 with signs 1,1,1,0 -> out_min1=31, out_min2=31, out_idx=0, out_sign_prod=1.
REQ-033 SHALL cover: out_ready held 0 while two rows stream -> in_ready=0 on the 2nd row's 4th message until out_ready=1; both results are correct and nothing is lost or duplicated.
REQ-034 SHALL cover: rst_n pulsed after 2 accepts, then a row of mags 9,4,6,2 -> out_min1=2, out_idx=3, out_min2=4.
REQ-035 SHALL cover: out_ready=1 in the same cycle a new last message is accepted -> out_valid stays 1 with no gap and the new result appears.
REQ-036 SHALL cover: with RPU_MINF_OFFSET_EN and OFFSET=1, mags 0,2,4,6 -> out_min1=0 (floored at zero), out_min2=1.
